stage_memory_access: RTL and testbench
======================================

# stage_memory_access

Pipeline stage directly downstream of the execute stage. It consumes the effective address, store operand and destination data that execute produces, and runs one data-memory transaction per instruction over a request/grant/response bus. It formats load data and stores it for write-back, tracks the LL/SC link bit, and holds the pipeline with `wait_mem` while a transaction is in flight.

## Interface
Parameters:
- `ADDR_W`, 32, memory address width.
- `DATA_W`, 32, data width; only 32 is supported.

Ports:
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-low reset.
- `in_valid` in 1: an instruction from execute is present.
- `mem_op` in `mem_op_t`: operation; one of NONE, LB, LBU, LH, LHU, LW, LWL, LWR, SB, SH, SW, LL, SC.
- `mem_addr` in ADDR_W: effective address, computed as rs + sign_immed.
- `rt_data` in 32: store operand, and merge source for LWL/LWR.
- `dest_reg_data` in 32: non-memory result, passed through.
- `dest_reg` in 5: destination register.
- `nullify` in 1: kill the current instruction.
- `eret` in 1: clears the link bit.
- `stall_in` in 1: downstream stall.
- `mem_req` out 1: bus request.
- `mem_we` out 1: write enable.
- `mem_addr_o` out ADDR_W: word-aligned address.
- `mem_be` out 4: byte enables.
- `mem_wdata` out 32: write data.
- `mem_gnt` in 1: request accepted.
- `mem_rvalid` in 1: read data valid.
- `mem_rdata` in 32: read data.
- `out_valid` out 1: result is valid.
- `out_data` out 32: write-back data.
- `out_reg` out 5: destination register.
- `exc_adel` out 1: load address error.
- `exc_ades` out 1: store address error.
- `wait_mem` out 1: stall request to the pipeline.
- `llbit` out 1: link bit.

## Operation
- FSM states: IDLE, REQ, RESP, DONE.
- **IDLE**
  - `in_valid` & NONE: register `dest_reg_data`; `out_valid` is high the next cycle.
  - `in_valid` & memory op: check alignment first.
    - Misaligned means LH/LHU/SH with addr[0]=1, or LW/LL/SW/SC with addr[1:0]≠0.
    - Misaligned: raise `exc_adel`/`exc_ades` for one cycle, issue no bus request, stay in IDLE.
    - Aligned: capture the operands and go to REQ.
- **SC with `llbit`=0:** no bus transaction. `out_data`=0 next cycle.
- **REQ:** hold `mem_req`=1 with stable address, byte enables and data until `mem_gnt`. Then go to RESP for loads, or to DONE for stores.
- **RESP:** wait for `mem_rvalid`, then go to DONE.
- **DONE:** `out_valid`=1; hold while `stall_in`; return to IDLE when `stall_in`=0.
- **Byte enables and write data:**
  - SB: be = 1<<addr[1:0]; data replicated in all byte lanes.
  - SH: be = 0011 or 1100; data replicated in both halves.
  - SW/SC: be = 1111.
  - Reads are issued with be=1111.
- **Load formatting** (little-endian):
  - LB/LH: sign-extend.
  - LBU/LHU: zero-extend.
  - LWL: bytes [3:3-k] of `rdata` merge into the high bytes of rt, where k = 3−addr[1:0].
  - LWR: bytes [3:addr[1:0]] of `rdata` merge into the low bytes of rt.
- **Link bit:**
  - LL sets `llbit` in the cycle the response arrives.
  - SC returns the `llbit` value (1 or 0) in `out_data`, then clears `llbit`.
  - `eret` clears `llbit`. If `eret` and an LL response arrive in the same cycle, the clear wins.
- **Nullify:**
  - In IDLE or REQ before `mem_gnt`: drop `mem_req` and return to IDLE.
  - After grant: finish the bus handshake but suppress `out_valid` and any `llbit` update.

## Timing
- **Reset values:**
  - State IDLE.
  - `mem_req`, `mem_we`, `out_valid`, `exc_*`, `llbit`, `wait_mem` are 0.
  - `mem_be`, `mem_addr_o`, `mem_wdata`, `out_*` are 0.
  - Reset mid-transaction abandons it.
- **`wait_mem`** is combinational: high in the cycle an aligned op is accepted, and in REQ and RESP.
- **Minimum latency:**
  - Load: op at cycle 0, `mem_req` cycle 1, gnt cycle 1, rvalid cycle 2, `out_valid` cycle 3.
  - Store: `out_valid` cycle 2.
- **Bus rules:**
  - `mem_req` is registered and never deasserts before `mem_gnt` unless nullified.
  - At most one transaction is outstanding.
  - `mem_rvalid` in REQ or IDLE is ignored.

## Structure
- Package `mem_access_pkg` holds `mem_op_t` and the `state_t` enum.
- Sub-module `load_data_aligner` is purely combinational: inputs `mem_op`, addr[1:0], `rdata`, `rt_data`; output formatted data.

## Test plan
- LW to 0x100; gnt at cycle 1, rvalid at cycle 3 with rdata=0xDEADBEEF -> `wait_mem` high cycles 0–3, `out_valid` at cycle 4 with `out_data`=0xDEADBEEF.
- LB addr 0x103, rdata=0x80123456 -> 0xFFFFFF80. LBU at the same address -> 0x00000080.
- SH addr 0x102, rt=0x0000ABCD -> be=1100, wdata=0xABCDABCD, `mem_we`=1, `out_valid` after gnt.
- LW addr 0x102 -> `exc_adel` for 1 cycle, `mem_req` never asserted.
- LL 0x200, then SC 0x200 -> `out_data`=1, `llbit`=0. LL, `eret`, SC -> `out_data`=0 and no bus request.
- `nullify` during REQ before gnt -> `mem_req` drops next cycle, no `out_valid`. Reset asserted in RESP -> all outputs 0 immediately.

Source files
------------

// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared types and decode helpers for the memory-access stage.
package mem_access_pkg;

    typedef enum logic [3:0] {
        OP_NONE, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR,
        OP_SB, OP_SH, OP_SW, OP_LL, OP_SC
    } mem_op_t;

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    function automatic logic is_store(input mem_op_t op);
        return op inside {OP_SB, OP_SH, OP_SW, OP_SC};
    endfunction

    function automatic logic misaligned(input mem_op_t op, input logic [1:0] a);
        return (op inside {OP_LH, OP_LHU, OP_SH} && a[0]) ||
               (op inside {OP_LW, OP_LL, OP_SW, OP_SC} && a != 2'b00);
    endfunction

endpackage

// File: rtl/load_data_aligner.sv
// load_data_aligner: little-endian extraction, extension and LWL/LWR merging of load data.
module load_data_aligner
    import mem_access_pkg::*;
(
    input  mem_op_t     mem_op,
    input  logic [1:0]  addr,
    input  logic [31:0] rdata,
    input  logic [31:0] rt_data,
    output logic [31:0] data
);
    logic [4:0]  sh;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] ml;
    logic [31:0] mr;

    always_comb begin
        sh   = {addr, 3'b000};
        b    = rdata[sh +: 8];
        h    = addr[1] ? rdata[31:16] : rdata[15:0];
        ml   = 32'hFFFF_FFFF << sh;
        mr   = 32'hFFFF_FFFF >> sh;
        data = mem_op == OP_LB  ? {{24{b[7]}}, b} :
               mem_op == OP_LBU ? {24'b0, b} :
               mem_op == OP_LH  ? {{16{h[15]}}, h} :
               mem_op == OP_LHU ? {16'b0, h} :
               mem_op == OP_LWL ? (rdata & ml) | (rt_data & ~ml) :
               mem_op == OP_LWR ? ((rdata >> sh) & mr) | (rt_data & ~mr) :
               rdata;
    end
endmodule

// File: rtl/stage_memory_access.sv
// stage_memory_access: one data-memory bus transaction per instruction, load formatting and LL/SC link tracking.
module stage_memory_access
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  mem_op_t           mem_op,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [DATA_W-1:0] dest_reg_data,
    input  logic [4:0]        dest_reg,
    input  logic              nullify,
    input  logic              eret,
    input  logic              stall_in,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [3:0]        mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [4:0]        out_reg,
    output logic              exc_adel,
    output logic              exc_ades,
    output logic              wait_mem,
    output logic              llbit
);
    state_t      state, state_d;
    mem_op_t     op_q;
    logic [1:0]  off_q;
    logic [31:0] rt_q;
    logic [4:0]  reg_q;
    logic        kill_q;
    logic [31:0] aligned;
    logic        none_ok, accept, bad, sc_fail, go, done_ld, done_st, fin, killed;
    logic [3:0]  be_d;
    logic [31:0] wd_d;

    load_data_aligner u_align (
        .mem_op  (op_q),
        .addr    (off_q),
        .rdata   (mem_rdata),
        .rt_data (rt_q),
        .data    (aligned)
    );

    always_comb begin
        none_ok  = state == IDLE && in_valid && !nullify && mem_op == OP_NONE;
        accept   = state == IDLE && in_valid && !nullify && mem_op != OP_NONE;
        bad      = accept && misaligned(mem_op, mem_addr[1:0]);
        sc_fail  = accept && !bad && mem_op == OP_SC && !llbit;
        go       = accept && !bad && !sc_fail;
        wait_mem = go || state == REQ || state == RESP;
        done_ld  = state == RESP && mem_rvalid;
        done_st  = state == REQ && mem_gnt && is_store(op_q);
        fin      = done_ld || done_st;
        killed   = kill_q || nullify;
        be_d     = mem_op == OP_SB ? 4'b0001 << mem_addr[1:0] :
                   mem_op == OP_SH ? (mem_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wd_d     = mem_op == OP_SB ? {4{rt_data[7:0]}} :
                   mem_op == OP_SH ? {2{rt_data[15:0]}} : rt_data;
    end

    // A transaction killed after grant skips DONE so no result is ever presented.
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = go ? REQ : IDLE;
            REQ:     state_d = mem_gnt ? (is_store(op_q) ? (killed ? IDLE : DONE) : RESP) :
                               nullify ? IDLE : REQ;
            RESP:    state_d = mem_rvalid ? (killed ? IDLE : DONE) : RESP;
            default: state_d = stall_in ? DONE : IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            op_q       <= OP_NONE;
            off_q      <= '0;
            rt_q       <= '0;
            reg_q      <= '0;
            kill_q     <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr_o <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_reg    <= '0;
            exc_adel   <= 1'b0;
            exc_ades   <= 1'b0;
            llbit      <= 1'b0;
        end else begin
            state    <= state_d;
            exc_adel <= bad && !is_store(mem_op);
            exc_ades <= bad && is_store(mem_op);
            kill_q   <= go ? 1'b0 : (state inside {REQ, RESP}) && nullify ? 1'b1 : kill_q;
            if (go) begin
                op_q       <= mem_op;
                off_q      <= mem_addr[1:0];
                rt_q       <= rt_data;
                reg_q      <= dest_reg;
                mem_req    <= 1'b1;
                mem_we     <= is_store(mem_op);
                mem_addr_o <= {mem_addr[ADDR_W-1:2], 2'b00};
                mem_be     <= be_d;
                mem_wdata  <= wd_d;
            end else if (state == REQ && (mem_gnt || nullify)) begin
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
            end
            out_valid <= none_ok || sc_fail || (fin && !killed) || (state == DONE && stall_in);
            if (none_ok || sc_fail) begin
                out_data <= none_ok ? dest_reg_data : '0;
                out_reg  <= dest_reg;
            end else if (fin) begin
                out_data <= done_ld ? aligned : {31'b0, op_q == OP_SC};
                out_reg  <= reg_q;
            end
            llbit <= eret ? 1'b0 :
                     done_ld && op_q == OP_LL && !killed ? 1'b1 :
                     done_st && op_q == OP_SC && !killed ? 1'b0 : llbit;
        end
    end
endmodule

// File: tb/tb_stage_memory_access.sv
// tb_stage_memory_access: directed stimulus with a queue scoreboard checked by an output monitor.
module tb_stage_memory_access;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    mem_op_t     mem_op = OP_NONE;
    logic [31:0] mem_addr = '0;
    logic [31:0] rt_data = '0;
    logic [31:0] dest_reg_data = '0;
    logic [4:0]  dest_reg = '0;
    logic        nullify = 1'b0;
    logic        eret = 1'b0;
    logic        stall_in = 1'b0;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        mem_req, mem_we, out_valid, exc_adel, exc_ades, wait_mem, llbit;
    logic [31:0] mem_addr_o, mem_wdata, out_data;
    logic [3:0]  mem_be;
    logic [4:0]  out_reg;

    typedef struct packed {logic [31:0] d; logic [4:0] r;} exp_t;
    exp_t sb_q[$];
    exp_t mon_e;
    int checks = 0;
    int fails = 0;

    always #5 clk = ~clk;

    stage_memory_access #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .mem_op(mem_op), .mem_addr(mem_addr),
        .rt_data(rt_data), .dest_reg_data(dest_reg_data), .dest_reg(dest_reg),
        .nullify(nullify), .eret(eret), .stall_in(stall_in),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr_o(mem_addr_o), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_data(out_data), .out_reg(out_reg),
        .exc_adel(exc_adel), .exc_ades(exc_ades), .wait_mem(wait_mem), .llbit(llbit)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input logic [31:0] d, input logic [4:0] r);
        exp_t e;
        e.d = d;
        e.r = r;
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (reset && out_valid && !stall_in) begin
            if (sb_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_out: got out_valid with data %h, expected no result", out_data);
            end else begin
                mon_e = sb_q.pop_front();
                chk("out_data", out_data, mon_e.d);
                chk("out_reg", {27'b0, out_reg}, {27'b0, mon_e.r});
            end
        end
    end

    // Full bus transaction: gl idle REQ cycles before grant, rl RESP cycles before rvalid, st DONE stall cycles.
    task automatic run(input mem_op_t op, input logic [31:0] addr, input logic [31:0] rt,
                       input logic [31:0] rdata, input int gl, input int rl, input logic ewe,
                       input logic [3:0] ebe, input logic [31:0] ewd, input logic [31:0] exp,
                       input logic [4:0] rd, input int st);
        in_valid = 1'b1;
        mem_op   = op;
        mem_addr = addr;
        rt_data  = rt;
        dest_reg = rd;
        expect_out(exp, rd);
        #1 chk("wait_accept", {31'b0, wait_mem}, 32'd1);
        step();
        in_valid = 1'b0;
        mem_op   = OP_NONE;
        chk("req", {31'b0, mem_req}, 32'd1);
        chk("wait_req", {31'b0, wait_mem}, 32'd1);
        chk("addr", mem_addr_o, {addr[31:2], 2'b00});
        chk("be", {28'b0, mem_be}, {28'b0, ebe});
        chk("we", {31'b0, mem_we}, {31'b0, ewe});
        if (ewe) chk("wdata", mem_wdata, ewd);
        for (int i = 0; i < gl; i++) begin
            step();
            chk("req_hold", {30'b0, mem_req, wait_mem}, 32'd3);
        end
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        if (!ewe) begin
            for (int i = 0; i < rl; i++) begin
                chk("wait_resp", {30'b0, mem_req, wait_mem}, 32'd1);
                step();
            end
            chk("wait_rv", {30'b0, mem_req, wait_mem}, 32'd1);
            mem_rvalid = 1'b1;
            mem_rdata  = rdata;
            step();
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
        end
        chk("out_valid", {31'b0, out_valid}, 32'd1);
        chk("wait_done", {31'b0, wait_mem}, 32'd0);
        stall_in = st > 0;
        for (int i = 0; i < st; i++) begin
            step();
            chk("stall_hold", {31'b0, out_valid}, 32'd1);
        end
        stall_in = 1'b0;
        step();
        chk("ov_drop", {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected end of stimulus");
        $fatal(1, "timeout");
    end

    initial begin
        #12;
        chk("rst_ctrl", {25'b0, mem_req, mem_we, out_valid, exc_adel, exc_ades, llbit, wait_mem}, 32'd0);
        chk("rst_bus", {28'b0, mem_be} | mem_addr_o | mem_wdata, 32'd0);
        chk("rst_out", out_data | {27'b0, out_reg}, 32'd0);
        step();
        reset = 1'b1;
        step();

        run(OP_LW,  32'h100, 32'h0, 32'hDEADBEEF, 0, 1, 1'b0, 4'hF, 32'h0, 32'hDEADBEEF, 5'd5, 0);
        run(OP_LB,  32'h103, 32'h0, 32'h80123456, 0, 0, 1'b0, 4'hF, 32'h0, 32'hFFFFFF80, 5'd1, 0);
        run(OP_LBU, 32'h103, 32'h0, 32'h80123456, 1, 0, 1'b0, 4'hF, 32'h0, 32'h00000080, 5'd2, 0);
        run(OP_LH,  32'h102, 32'h0, 32'h80011234, 0, 0, 1'b0, 4'hF, 32'h0, 32'hFFFF8001, 5'd3, 0);
        run(OP_LHU, 32'h100, 32'h0, 32'h0000F00F, 0, 0, 1'b0, 4'hF, 32'h0, 32'h0000F00F, 5'd4, 0);
        run(OP_LWR, 32'h101, 32'hAABBCCDD, 32'h44332211, 0, 0, 1'b0, 4'hF, 32'h0, 32'hAA443322, 5'd11, 0);
        run(OP_LWL, 32'h101, 32'hAABBCCDD, 32'h44332211, 0, 0, 1'b0, 4'hF, 32'h0, 32'h443322DD, 5'd12, 0);
        run(OP_SH,  32'h102, 32'h0000ABCD, 32'h0, 0, 0, 1'b1, 4'b1100, 32'hABCDABCD, 32'h0, 5'd6, 0);
        run(OP_SB,  32'h101, 32'h12345677, 32'h0, 2, 0, 1'b1, 4'b0010, 32'h77777777, 32'h0, 5'd7, 2);

        in_valid = 1'b1; mem_op = OP_LW; mem_addr = 32'h102;
        #1 chk("mis_wait", {31'b0, wait_mem}, 32'd0);
        step();
        in_valid = 1'b0;
        chk("adel", {29'b0, exc_adel, exc_ades, mem_req}, 32'b100);
        step();
        chk("adel_pulse", {29'b0, exc_adel, mem_req, out_valid}, 32'd0);
        in_valid = 1'b1; mem_op = OP_SW; mem_addr = 32'h101;
        step();
        in_valid = 1'b0;
        chk("ades", {29'b0, exc_adel, exc_ades, mem_req}, 32'b010);
        step();

        in_valid = 1'b1; mem_op = OP_NONE; dest_reg_data = 32'hCAFEF00D; dest_reg = 5'd9;
        expect_out(32'hCAFEF00D, 5'd9);
        #1 chk("none_wait", {31'b0, wait_mem}, 32'd0);
        step();
        in_valid = 1'b0;
        chk("none_ov", {30'b0, out_valid, mem_req}, 32'b10);
        step();

        run(OP_LL, 32'h200, 32'h0, 32'h11112222, 0, 0, 1'b0, 4'hF, 32'h0, 32'h11112222, 5'd8, 0);
        chk("ll_set", {31'b0, llbit}, 32'd1);
        run(OP_SC, 32'h200, 32'h5, 32'h0, 1, 0, 1'b1, 4'hF, 32'h5, 32'h1, 5'd10, 0);
        chk("sc_clear", {31'b0, llbit}, 32'd0);

        run(OP_LL, 32'h204, 32'h0, 32'h0, 0, 0, 1'b0, 4'hF, 32'h0, 32'h0, 5'd13, 0);
        chk("ll_set2", {31'b0, llbit}, 32'd1);
        eret = 1'b1;
        step();
        eret = 1'b0;
        chk("eret_clear", {31'b0, llbit}, 32'd0);
        in_valid = 1'b1; mem_op = OP_SC; mem_addr = 32'h204; rt_data = 32'h9; dest_reg = 5'd14;
        expect_out(32'h0, 5'd14);
        #1 chk("scf_wait", {31'b0, wait_mem}, 32'd0);
        step();
        in_valid = 1'b0; mem_op = OP_NONE;
        chk("scf_ov", {30'b0, mem_req, out_valid}, 32'b01);
        step();
        chk("scf_idle", {30'b0, mem_req, out_valid}, 32'd0);

        in_valid = 1'b1; mem_op = OP_LW; mem_addr = 32'h300; dest_reg = 5'd15;
        step();
        in_valid = 1'b0; mem_op = OP_NONE;
        chk("null_req", {31'b0, mem_req}, 32'd1);
        nullify = 1'b1;
        step();
        nullify = 1'b0;
        chk("null_drop", {30'b0, mem_req, wait_mem}, 32'd0);
        repeat (3) step();
        chk("null_no_ov", {31'b0, out_valid}, 32'd0);

        in_valid = 1'b1; mem_op = OP_LL; mem_addr = 32'h200; dest_reg = 5'd16;
        step();
        in_valid = 1'b0; mem_op = OP_NONE; mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0; nullify = 1'b1;
        step();
        nullify = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
        chk("kill_wait", {31'b0, wait_mem}, 32'd1);
        step();
        mem_rvalid = 1'b0;
        chk("kill_ll", {29'b0, llbit, out_valid, wait_mem}, 32'd0);
        step();

        run(OP_LL, 32'h208, 32'h0, 32'h5A5A5A5A, 0, 0, 1'b0, 4'hF, 32'h0, 32'h5A5A5A5A, 5'd17, 0);
        in_valid = 1'b1; mem_op = OP_LW; mem_addr = 32'h30C; dest_reg = 5'd18;
        step();
        in_valid = 1'b0; mem_op = OP_NONE; mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        chk("pre_rst", {30'b0, llbit, wait_mem}, 32'd3);
        #1 reset = 1'b0;
        #1;
        chk("arst_ctrl", {25'b0, mem_req, mem_we, out_valid, exc_adel, exc_ades, llbit, wait_mem}, 32'd0);
        chk("arst_bus", {28'b0, mem_be} | mem_addr_o | mem_wdata, 32'd0);
        chk("arst_out", out_data | {27'b0, out_reg}, 32'd0);
        step();
        reset = 1'b1;
        step();
        run(OP_LW, 32'h104, 32'h0, 32'h01020304, 0, 0, 1'b0, 4'hF, 32'h0, 32'h01020304, 5'd19, 0);

        repeat (3) step();
        chk("sb_empty", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
